// File: rtl/branch_predictor_pkg.sv
// Shared predictor types: PC width, 2-bit counter encoding, controller states
// and the table entry layout.
package branch_predict_inc;

   localparam int PC_W = 32;
   typedef logic [PC_W-1:0] pc_t;

   // Widest tag occurs with the smallest table (16 entries -> 4 index bits).
   localparam int TAG_W_MAX = PC_W - 4 - 2;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } bp_ctr_t;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } bp_state_t;

   // Tags narrower than TAG_W_MAX are stored zero-extended.
   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
      pc_t                  target;
      bp_ctr_t              ctr;
   } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Two-bit saturating taken/not-taken counter step.
module bp_sat_counter
   import branch_predict_inc::*;
(
   input  logic [1:0] i_ctr,
   input  logic       i_taken,
   output logic [1:0] o_ctr_nxt
);

   // Move one step toward the resolved outcome, holding at either end.
   always_comb begin
      o_ctr_nxt = i_ctr;
      if (i_taken) begin
         if (i_ctr != CTR_ST) o_ctr_nxt = i_ctr + 2'd1;
      end else begin
         if (i_ctr != CTR_SNT) o_ctr_nxt = i_ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with 2-bit counters and a branch target
// per entry. Table contents are initialised by a one-index-per-cycle sweep.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | sweeping entries to invalid/weak-NT; updates ignored,
//         | lookups always predict not-taken
//   READY | normal lookup/update operation
module branch_predictor
   import branch_predict_inc::*;
#(
   parameter int BP_ENTRIES = 64
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        invalidate,
   output logic        ready
);

   localparam int IDX = $clog2(BP_ENTRIES);
   localparam logic [IDX-1:0] SWEEP_LAST = IDX'(BP_ENTRIES - 1);

   bp_state_t r_state;
   bp_state_t w_state_nxt;
   logic [IDX-1:0] r_sweep_idx;
   logic [IDX-1:0] w_sweep_nxt;

   bp_entry_t r_mem [BP_ENTRIES];

   logic        r_pred_valid;
   logic        r_pred_taken;
   logic [31:0] r_pred_target;

   logic [IDX-1:0]       w_lkp_idx;
   logic [IDX-1:0]       w_upd_idx;
   logic [TAG_W_MAX-1:0] w_lkp_tag;
   logic [TAG_W_MAX-1:0] w_upd_tag;
   bp_entry_t            w_lkp_ent;
   bp_entry_t            w_upd_ent;
   logic                 w_lkp_hit;
   logic                 w_upd_hit;
   logic                 w_pred_taken;
   logic [1:0]           w_ctr_nxt;

   logic           w_wr_en;
   logic [IDX-1:0] w_wr_idx;
   bp_entry_t      w_wr_data;

   logic w_unused;
   assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign w_lkp_idx = lookup_pc[IDX+1:2];
   assign w_upd_idx = upd_pc[IDX+1:2];
   assign w_lkp_tag = TAG_W_MAX'(lookup_pc >> (IDX + 2));
   assign w_upd_tag = TAG_W_MAX'(upd_pc >> (IDX + 2));

   assign w_lkp_ent = r_mem[w_lkp_idx];
   assign w_upd_ent = r_mem[w_upd_idx];
   assign w_lkp_hit = w_lkp_ent.valid && (w_lkp_ent.tag == w_lkp_tag);
   assign w_upd_hit = w_upd_ent.valid && (w_upd_ent.tag == w_upd_tag);

   assign w_pred_taken = lookup_valid && (r_state == READY) && w_lkp_hit && w_lkp_ent.ctr[1];

   bp_sat_counter u_sat_counter (
      .i_ctr     (w_upd_ent.ctr),
      .i_taken   (upd_taken),
      .o_ctr_nxt (w_ctr_nxt)
   );

   // State register and sweep pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= CLEAR;
         r_sweep_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_idx <= w_sweep_nxt;
      end
   end

   // Next state: advance the sweep, restart it on invalidate.
   always_comb begin
      w_state_nxt = r_state;
      w_sweep_nxt = r_sweep_idx;
      case (r_state)
         CLEAR: begin
            if (invalidate) begin
               w_sweep_nxt = '0;
            end else if (r_sweep_idx == SWEEP_LAST) begin
               w_state_nxt = READY;
               w_sweep_nxt = '0;
            end else begin
               w_sweep_nxt = r_sweep_idx + IDX'(1);
            end
         end
         READY: begin
            if (invalidate) begin
               w_state_nxt = CLEAR;
               w_sweep_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = CLEAR;
            w_sweep_nxt = '0;
         end
      endcase
   end

   // Single table write port: sweep clear, counter/target training or allocation.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_idx  = r_sweep_idx;
      w_wr_data = '0;
      if (r_state == CLEAR) begin
         w_wr_en       = 1'b1;
         w_wr_data.ctr = CTR_WNT;
      end else if (!invalidate && upd_valid) begin
         w_wr_idx = w_upd_idx;
         if (w_upd_hit) begin
            w_wr_en       = 1'b1;
            w_wr_data     = w_upd_ent;
            w_wr_data.ctr = bp_ctr_t'(w_ctr_nxt);
            if (upd_taken) w_wr_data.target = upd_target;
         end else if (upd_taken) begin
            w_wr_en          = 1'b1;
            w_wr_data.valid  = 1'b1;
            w_wr_data.tag    = w_upd_tag;
            w_wr_data.target = upd_target;
            w_wr_data.ctr    = CTR_WT;
         end
      end
   end

   // Table storage; contents come only from the sweep, so no reset here.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
   end

   // Registered prediction; reads the table before this cycle's write lands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pred_valid  <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= '0;
      end else begin
         r_pred_valid  <= lookup_valid;
         r_pred_taken  <= w_pred_taken;
         r_pred_target <= w_pred_taken ? w_lkp_ent.target : '0;
      end
   end

   assign pred_valid  = r_pred_valid;
   assign pred_taken  = r_pred_taken;
   assign pred_target = r_pred_target;
   assign ready       = (r_state == READY);

endmodule
